// File: rtl/frv_mem_rsp_pkg.sv
// Shared types and helpers for the frv memory responder.
// Optional stall injection in the top is enabled with FRV_MEM_RSP_STALL_EN.
package frv_mem_rsp_pkg;

  localparam int STRB_W = 4;
  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;

  typedef struct packed {
    logic              error;
    logic [DATA_W-1:0] rdata;
  } frv_mem_rsp_t;

  // Bit width needed to index 'depth' entries, never less than 1.
  function automatic int ptr_w(input int depth);
    return (depth <= 1) ? 1 : $clog2(depth);
  endfunction

endpackage

// File: rtl/frv_mem_rsp_fifo.sv
// In-order response FIFO: DEPTH entries of frv_mem_rsp_t, head exposed combinationally.
// The owner never pushes when full nor pops when empty.
module frv_mem_rsp_fifo
  import frv_mem_rsp_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         push,
  input  logic                         pop,
  input  frv_mem_rsp_t                 din,
  output frv_mem_rsp_t                 head,
  output logic                         full,
  output logic                         empty,
  output logic [ptr_w(DEPTH+1)-1:0]    count
);

  localparam int PW = ptr_w(DEPTH);
  localparam int CW = ptr_w(DEPTH + 1);

  frv_mem_rsp_t   store [DEPTH];
  logic [PW-1:0]  rd_ptr;
  logic [PW-1:0]  wr_ptr;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= ptr_inc(wr_ptr);
      if (pop)  rd_ptr <= ptr_inc(rd_ptr);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Payload storage needs no reset: it is only observed through a non-empty head.
  always_ff @(posedge clk) begin
    if (push) store[wr_ptr] <= din;
  end

  assign head  = store[rd_ptr];
  assign full  = (count == CW'(DEPTH));
  assign empty = (count == '0);

endmodule

// File: rtl/frv_mem_responder.sv
// Memory-side responder for the frv req/gnt/recv/ack bus with a word SRAM model.
// Define FRV_MEM_RSP_STALL_EN to add LFSR-driven gnt/recv stalls.
module frv_mem_responder
  import frv_mem_rsp_pkg::*;
#(
  parameter int          MEM_WORDS       = 1024,
  parameter logic [31:0] ADDR_BASE       = 32'h0000_0000,
  parameter int          MAX_OUTSTANDING = 2,
  parameter int          RSP_LATENCY     = 1,
  parameter logic [7:0]  LFSR_SEED       = 8'h5A
) (
  input  logic              g_clk,
  input  logic              g_reset,
  input  logic              mem_req,
  input  logic              mem_wen,
  input  logic [STRB_W-1:0] mem_strb,
  input  logic [DATA_W-1:0] mem_wdata,
  input  logic [ADDR_W-1:0] mem_addr,
  output logic              mem_gnt,
  input  logic              mem_ack,
  output logic              mem_recv,
  output logic              mem_error,
  output logic [DATA_W-1:0] mem_rdata
);

  localparam int          IDX_W    = ptr_w(MEM_WORDS);
  localparam int          LCW      = ptr_w(RSP_LATENCY + 1);
  localparam int          FCW      = ptr_w(MAX_OUTSTANDING + 1);
  localparam logic [63:0] SPAN     = 64'(MEM_WORDS) << 2;
  localparam logic [LCW-1:0] LAT_LOAD = LCW'(RSP_LATENCY - 1);

  if (MAX_OUTSTANDING < 1) begin : g_bad_depth
    $error("frv_mem_responder: MAX_OUTSTANDING must be >= 1");
  end
  if (RSP_LATENCY < 1) begin : g_bad_lat
    $error("frv_mem_responder: RSP_LATENCY must be >= 1");
  end
  if (LFSR_SEED == 8'h00) begin : g_bad_seed
    $error("frv_mem_responder: LFSR_SEED must be nonzero");
  end

  logic [DATA_W-1:0] mem [MEM_WORDS];

  logic              rdy_q;
  logic [31:0]       byte_off;
  logic              addr_ok;
  logic [IDX_W-1:0]  idx;
  logic              push;
  logic              pop;
  logic              new_head;
  logic              head_ready;
  logic [LCW-1:0]    lat_cnt;
  frv_mem_rsp_t      push_rsp;
  frv_mem_rsp_t      head_rsp;
  logic              fifo_full;
  logic              fifo_empty;
  logic [FCW-1:0]    fifo_count;

  // A borrow in byte_off is caught by the explicit lower-bound compare.
  assign byte_off = mem_addr - ADDR_BASE;
  assign addr_ok  = (mem_addr[1:0] == 2'b00) && (mem_addr >= ADDR_BASE) &&
                    ({32'b0, byte_off} < SPAN);
  assign idx      = byte_off[IDX_W+1:2];

  assign push = mem_req && mem_gnt;
  assign pop  = mem_recv && mem_ack;

  always_comb begin
    push_rsp       = '0;
    push_rsp.error = !addr_ok;
    if (addr_ok && !mem_wen) push_rsp.rdata = mem[idx];
  end

  always_ff @(posedge g_clk) begin
    if (push && addr_ok && mem_wen) begin
      for (int b = 0; b < STRB_W; b++) begin
        if (mem_strb[b]) mem[idx][8*b +: 8] <= mem_wdata[8*b +: 8];
      end
    end
  end

  frv_mem_rsp_fifo #(.DEPTH(MAX_OUTSTANDING)) u_fifo (
    .clk   (g_clk),
    .rst   (g_reset),
    .push  (push),
    .pop   (pop),
    .din   (push_rsp),
    .head  (head_rsp),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  // A new head appears on a push into an empty queue or on a pop that leaves something behind.
  assign new_head = (push && fifo_empty) ||
                    (pop && ((fifo_count != FCW'(1)) || push));

  // lat_cnt counts the head cycles still to wait; the cycle after the load is the first head cycle.
  always_ff @(posedge g_clk or posedge g_reset) begin
    if (g_reset) begin
      lat_cnt <= '0;
      rdy_q   <= 1'b0;
    end else begin
      rdy_q <= 1'b1;
      if (new_head)           lat_cnt <= LAT_LOAD;
      else if (lat_cnt != '0) lat_cnt <= lat_cnt - LCW'(1);
    end
  end

  assign head_ready = !fifo_empty && (lat_cnt == '0);

`ifdef FRV_MEM_RSP_STALL_EN
  logic [7:0] lfsr;
  logic       recv_q;

  // recv_q remembers an unconsumed response so a stall never withdraws an asserted recv.
  always_ff @(posedge g_clk or posedge g_reset) begin
    if (g_reset) begin
      lfsr   <= LFSR_SEED;
      recv_q <= 1'b0;
    end else begin
      lfsr   <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
      recv_q <= mem_recv && !mem_ack;
    end
  end

  assign mem_gnt  = rdy_q && !fifo_full && !lfsr[0];
  assign mem_recv = head_ready && (recv_q || !lfsr[1]);
`else
  assign mem_gnt  = rdy_q && !fifo_full;
  assign mem_recv = head_ready;
`endif

  assign mem_rdata = mem_recv ? head_rsp.rdata : '0;
  assign mem_error = mem_recv && head_rsp.error;

endmodule
